// File: rtl/serial_receiver.sv
// serial_receiver: 8N1 asynchronous serial deserializer with a one-deep
// holding register, valid/ack handshake, framing-error pulse and sticky overrun.
module serial_receiver #(
  parameter int unsigned CLKS_PER_BIT = 10417,
  parameter int unsigned CNT_W        = 14
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       serialIn,
  input  logic       rd_ack,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned     HALF_BIT  = CLKS_PER_BIT / 2;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             busy_q, busy_d;
  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             rx;
  logic             good_byte;

  // Two-flop synchronizer; rx is the only view of the line used below.
  always_comb begin
    sync1_d = serialIn;
    sync2_d = sync1_q;
  end

  assign rx = sync2_q;

  // Frame sequencing: start validation, mid-bit sampling, stop check, break wait.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + CNT_ONE;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    good_byte   = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!rx) begin
          state_d = S_START;
        end
      end

      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rx) begin
            state_d   = S_DATA;
            bit_idx_d = 3'd0;
          end else begin
            // Start bit did not survive to its midpoint: line glitch.
            state_d = S_IDLE;
          end
        end
      end

      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          shift_d   = {rx, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end
        end
      end

      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx) begin
            good_byte = 1'b1;
            state_d   = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end
      end

      S_BREAK: begin
        // Held-low line is one error, not a stream of zero frames.
        cnt_d = '0;
        if (rx) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // Holding register: a simultaneous load and ack keeps the new byte valid.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;

    if (good_byte) begin
      if (!valid_q || rd_ack) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (rd_ack) begin
      valid_d = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      data_q      <= 8'h00;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_serial_receiver.sv
// tb_serial_receiver: directed and randomized 8N1 frames checked against a
// frame-level model of the holding register and error flags.
module tb_serial_receiver;

  localparam int unsigned CPB = 8;
  localparam int unsigned CW  = 4;

  logic       sysclk = 1'b0;
  logic       reset;
  logic       serialIn;
  logic       rd_ack;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_cmp   = 0;
  int n_bad   = 0;
  int fe_seen = 0;

  // Reference model state
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ovr;
  int         m_fe;

  serial_receiver #(.CLKS_PER_BIT(CPB), .CNT_W(CW)) dut (
    .sysclk   (sysclk),
    .reset    (reset),
    .serialIn (serialIn),
    .rd_ack   (rd_ack),
    .data     (data),
    .valid    (valid),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  always #5 sysclk = ~sysclk;

  // Count every cycle frame_err is seen high.
  always @(negedge sysclk) begin
    if (frame_err === 1'b1) fe_seen++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge sysclk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic exp_busy);
    chk({tag, "/data"},    32'(data),    32'(m_data));
    chk({tag, "/valid"},   32'(valid),   32'(m_valid));
    chk({tag, "/overrun"}, 32'(overrun), 32'(m_ovr));
    chk({tag, "/fe_cnt"},  32'(fe_seen), 32'(m_fe));
    chk({tag, "/busy"},    32'(busy),    32'(exp_busy));
  endtask

  task automatic model_reset();
    m_data  = 8'h00;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
  endtask

  // Outcome of one whole frame with rd_ack held constant throughout it.
  task automatic model_frame(input logic [7:0] b, input logic good);
    if (good) begin
      if (!m_valid || rd_ack) m_data = b;
      else                    m_ovr  = 1'b1;
      m_valid = rd_ack ? 1'b0 : 1'b1;
    end else begin
      m_fe++;
      if (rd_ack) m_valid = 1'b0;
    end
  endtask

  // Drive one 8N1 frame; optionally pulse reset mid-way through data bit abort_bit.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int abort_bit);
    serialIn = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      serialIn = b[i];
      if (i == abort_bit) begin
        tick(CPB / 2);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(CPB / 2 - 1);
      end else begin
        tick(CPB);
      end
    end
    serialIn = stop;
    tick(CPB);
  endtask

  task automatic ack_pulse();
    rd_ack = 1'b1;
    tick(1);
    rd_ack = 1'b0;
    if (m_valid) m_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    logic       good;

    reset    = 1'b1;
    serialIn = 1'b1;
    rd_ack   = 1'b0;
    m_fe     = 0;
    model_reset();
    tick(3);
    reset = 1'b0;
    tick(1);
    chk_all("reset", 1'b0);

    // Single byte
    send_frame(8'hA5, 1'b1, -1);
    model_frame(8'hA5, 1'b1);
    chk_all("single_a5", 1'b0);
    ack_pulse();
    chk_all("ack_a5", 1'b0);

    // Glitch rejection
    serialIn = 1'b0;
    tick(3);
    serialIn = 1'b1;
    chk("glitch/busy_hi", 32'(busy), 32'd1);
    tick(12);
    chk_all("glitch_done", 1'b0);

    // Framing error followed by held-low line
    send_frame(8'h3C, 1'b0, -1);
    model_frame(8'h3C, 1'b0);
    tick(40);
    chk_all("break_low", 1'b1);
    serialIn = 1'b1;
    tick(CPB);
    chk_all("break_release", 1'b0);
    send_frame(8'h81, 1'b1, -1);
    model_frame(8'h81, 1'b1);
    chk_all("after_break_81", 1'b0);
    ack_pulse();

    // Overrun with no acknowledge
    send_frame(8'h11, 1'b1, -1);
    model_frame(8'h11, 1'b1);
    chk_all("ovr_first", 1'b0);
    send_frame(8'h22, 1'b1, -1);
    model_frame(8'h22, 1'b1);
    chk_all("ovr_second", 1'b0);
    ack_pulse();
    chk_all("ovr_ack", 1'b0);

    // Ack held high while streaming back-to-back
    rd_ack = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      b = 8'(i);
      send_frame(b, 1'b1, -1);
      model_frame(b, 1'b1);
      chk_all("ack_stream", 1'b0);
    end
    rd_ack = 1'b0;
    tick(2);

    // Reset during bit 4, then a clean frame
    send_frame(8'hF0, 1'b1, 4);
    model_reset();
    chk_all("abort_f0", 1'b0);
    send_frame(8'h5A, 1'b1, -1);
    model_frame(8'h5A, 1'b1);
    chk_all("after_abort_5a", 1'b0);

    // Randomized frames, errors, gaps and acknowledges
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    model_reset();
    for (int n = 0; n < 30; n++) begin
      b      = 8'($urandom);
      good   = ($urandom_range(0, 4) != 0);
      rd_ack = ($urandom_range(0, 3) == 0);
      send_frame(b, good, -1);
      model_frame(b, good);
      if (!good) begin
        tick($urandom_range(0, 10));
        serialIn = 1'b1;
        tick(CPB);
      end
      chk_all("rand", 1'b0);
      rd_ack = 1'b0;
      if ($urandom_range(0, 2) == 0) ack_pulse();
      serialIn = 1'b1;
      tick($urandom_range(0, 12));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
